muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the EX stage of the 16-bit pipelined processor. When the EX control decode issues ALU control 4'b0100 (signed multiply) or 4'b0101 (signed divide), this block captures both operands and computes the result over 16 cycles with a shift-add or restoring-divide datapath. While it works, it holds the pipeline with `stall`. It then presents a full 32-bit result (low/high product, or quotient/remainder) for one cycle.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  EX-stage request valid; sampled only in IDLE.
- `alu_cntrl`  in  4  4'b0100 = MUL, 4'b0101 = DIV; any other value with `start` is ignored.
- `op1`  in  WIDTH  signed multiplicand / dividend.
- `op2`  in  WIDTH  signed multiplier / divisor.
- `flush`  in  1  abort the in-flight operation (branch taken).
- `stall`  out  1  freeze IF/ID/EX registers.
- `done`  out  1  one-cycle pulse; results valid.
- `result`  out  WIDTH  product low half / quotient.
- `result_hi`  out  WIDTH  product high half / remainder.
- `div_zero`  out  1  valid with `done`; divisor was 0.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE → CALC:** on `start` with a MUL or DIV code and `op2 != 0` (or any MUL).
  - Latch `|op1|`, `|op2|`, the op type, the result sign (`op1[15]^op2[15]`) and the remainder sign (`op1[15]`).
  - Clear the 32-bit accumulator and load the 5-bit iteration counter with 16.
- **IDLE → DONE (divide by zero):** DIV with `op2 == 0`.
  - `result` = 16'hFFFF, `result_hi` = `op1`, `div_zero` = 1.
- **CALC:** one iteration per cycle; the counter decrements.
  - MUL: shift-add on the magnitudes.
  - DIV: restoring; shift the remainder left, trial-subtract the divisor magnitude, set the quotient bit.
- **CALC → DONE:** when the counter reaches 0 after the 16th iteration.
  - Apply sign correction on this transition.
  - MUL: negate the 32-bit product if the result sign is set.
  - DIV: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set.
- **DONE → IDLE:** unconditional. `start` is ignored in DONE.
- **Output widths and signs:** magnitudes are 16-bit unsigned, so the magnitude of -32768 is 0x8000.
  - -32768 / -1 gives quotient 0x8000 (two's-complement wrap); no flag is raised.
  - All arithmetic is modulo 2^16 per half.
- **`flush`** in CALC or DONE → IDLE next cycle; `done` is not asserted. `flush` in IDLE has no effect, and in that cycle it overrides `start`.
- **Reset values:** state IDLE; `stall`, `done`, `div_zero` = 0; `result`, `result_hi` = 0; counter = 0.
- **Output registers:** `result`/`result_hi` hold their values until the next DONE.

## Timing
- `start` accepted at cycle T:
  - `stall` = 1 combinationally in cycle T (IDLE & `start` & valid code) and in T+1..T+16 (CALC).
  - DONE at T+17, with `done` = 1 and `stall` = 0, so EX advances that edge.
  - Total latency is 17 cycles; the pipeline loses 17 cycles per MUL/DIV.
- Divide by zero: `stall` = 1 at T only; DONE at T+1.
- `stall` is never high in DONE or IDLE except in the accepting cycle.
- `rst` mid-operation: IDLE on the next edge with all outputs at their reset values, and no `done`.
- `rst` has priority over `flush`, which has priority over `start`.

## Structure
- The shared processor package/defines file holds:
  - ALU control codes `ALU_MUL` = 4'b0100 and `ALU_DIV` = 4'b0101 (shared with the EX control decode);
  - the state encodings `MD_IDLE`, `MD_CALC`, `MD_DONE`.
- One sub-module, `muldiv_iter`: the combinational single-step datapath.
  - Inputs: accumulator, operand magnitude, op type.
  - Output: next accumulator.
  - The FSM, counter and sign handling stay in `muldiv_seq`.

## Test plan
- **MUL 7 × -3**, start at T: `stall` high T..T+16; `done` at T+17 with `result` = 16'hFFEB and `result_hi` = 16'hFFFF.
- **MUL edge case** 0x8000 × 0x8000: `result` = 16'h0000, `result_hi` = 16'h4000.
- **DIV -17 / 5:** `result` = 16'hFFFD (-3), `result_hi` = 16'hFFFE (-2), `div_zero` = 0; also -32768 / -1 gives `result` = 16'h8000, `result_hi` = 0.
- **DIV 100 / 0:** `stall` high one cycle; `done` at T+1 with `div_zero` = 1, `result` = 16'hFFFF, `result_hi` = 16'h0064.
- **Abort and restart:**
  - `flush` at T+5: IDLE at T+6, no `done`, `stall` low.
  - New MUL 3 × 4 at T+6 completes at T+23 with `result` = 16'h000C.
- **Ignored requests and reset:**
  - `start` pulsed during CALC and in DONE is ignored; only one `done` is produced.
  - `start` with `alu_cntrl` = 4'b0000 leaves the block IDLE with `stall` low.
  - `rst` at T+8 returns all outputs to 0.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared processor definitions: EX-stage ALU control codes and the
// multiply/divide sequencer state encoding.
package muldiv_seq_pkg;

  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_iter.sv
// Single iteration of the sequencer datapath: one shift-add multiply step
// or one restoring-divide step on unsigned magnitudes.
module muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mag_i,
  input  logic               bit_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] mul_nx;

  // Divide: acc = {remainder, quotient}; bit_i is the next dividend bit, MSB first.
  assign rem_sh = {acc_i[2*WIDTH-1:WIDTH], bit_i};
  assign ge     = rem_sh >= {1'b0, mag_i};
  assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, mag_i}) : rem_sh[WIDTH-1:0];

  // Multiply: bit_i is the next multiplier bit, MSB first, so shift then add.
  assign mul_nx = {acc_i[2*WIDTH-2:0], 1'b0} + (bit_i ? {{WIDTH{1'b0}}, mag_i} : '0);

  assign acc_o = is_div_i ? {rem_nx, acc_i[WIDTH-2:0], ge} : mul_nx;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide sequencer for the EX stage. Holds the
// pipeline with stall for WIDTH cycles, then presents a one-cycle done.
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              alu_cntrl,
  input  logic signed [WIDTH-1:0] op1,
  input  logic signed [WIDTH-1:0] op2,
  input  logic                    flush,
  output logic                    stall,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic [WIDTH-1:0]        result_hi,
  output logic                    div_zero
);
  import muldiv_seq_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
  logic [WIDTH-1:0]   mag_q, mag_d, sh_q, sh_d;
  logic               is_div_q, is_div_d;
  logic               rsign_q, rsign_d;
  logic               remsign_q, remsign_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
  logic               req_div, req_valid, accept;

  assign req_div   = alu_cntrl == ALU_DIV;
  assign req_valid = start && (alu_cntrl == ALU_MUL || req_div);
  assign accept    = (state_q == MD_IDLE) && req_valid && !flush;

  assign stall     = accept || (state_q == MD_CALC);
  assign done      = (state_q == MD_DONE) && !flush;
  assign div_zero  = done && dz_q;
  assign result    = res_q;
  assign result_hi = hi_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc_i    (acc_q),
    .mag_i    (mag_q),
    .bit_i    (sh_q[WIDTH-1]),
    .is_div_i (is_div_q),
    .acc_o    (acc_step)
  );

  assign prod = rsign_q ? -acc_step : acc_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    sh_d      = sh_q;
    is_div_d  = is_div_q;
    rsign_d   = rsign_q;
    remsign_d = remsign_q;
    dz_d      = dz_q;
    res_d     = res_q;
    hi_d      = hi_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          is_div_d = req_div;
          if (req_div && op2 == '0) begin
            state_d = MD_DONE;
            res_d   = '1;
            hi_d    = op1;
            dz_d    = 1'b1;
          end else begin
            // Multiply: add op1 magnitude per op2 bit; divide: shift op1 bits against |op2|.
            state_d   = MD_CALC;
            mag_d     = req_div ? abs_w(op2) : abs_w(op1);
            sh_d      = req_div ? abs_w(op1) : abs_w(op2);
            rsign_d   = op1[WIDTH-1] ^ op2[WIDTH-1];
            remsign_d = op1[WIDTH-1];
            acc_d     = '0;
            cnt_d     = CNT_W'(WIDTH);
            dz_d      = 1'b0;
          end
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = MD_DONE;
            if (is_div_q) begin
              res_d = cond_neg(acc_step[WIDTH-1:0], rsign_q);
              hi_d  = cond_neg(acc_step[2*WIDTH-1:WIDTH], remsign_q);
            end else begin
              res_d = prod[WIDTH-1:0];
              hi_d  = prod[2*WIDTH-1:WIDTH];
            end
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    mag_q     <= mag_d;
    sh_q      <= sh_d;
    is_div_q  <= is_div_d;
    rsign_q   <= rsign_d;
    remsign_q <= remsign_d;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus random
// MUL/DIV traffic checked against an integer-arithmetic reference.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst, start, flush;
  logic [3:0]         alu_cntrl;
  logic signed [15:0] op1, op2;
  logic               stall, done, div_zero;
  logic [15:0]        result, result_hi;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_cntrl (alu_cntrl),
    .op1       (op1),
    .op2       (op2),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b);
    int   sa, sbv, p, q, r;
    exp_t e;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    e   = '0;
    if (code == ALU_MUL) begin
      p     = sa * sbv;
      e.res = p[15:0];
      e.hi  = p[31:16];
    end else if (sbv == 0) begin
      e.res = 16'hFFFF;
      e.hi  = a;
      e.dz  = 1'b1;
    end else begin
      q     = sa / sbv;
      r     = sa % sbv;
      e.res = q[15:0];
      e.hi  = r[15:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("result_hi", 32'(result_hi), 32'(e.hi));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
      end
    end
  end

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic issue(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b, input bit push);
    start = 1'b1; alu_cntrl = code; op1 = a; op2 = b;
    if (push) exp_q.push_back(model(code, a, b));
    @(negedge clk);
    chk("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; alu_cntrl = 4'($urandom); op1 = 16'($urandom); op2 = 16'($urandom);
  endtask

  task automatic wait_done(input int exp_lat, input int exp_stalls, input bit poke_calc, input bit poke_done);
    int lat = 0;
    int stalls = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin seen = 1'b1; break; end
      if (stall) stalls++;
      if (poke_calc && lat == 3) begin start = 1'b1; alu_cntrl = ALU_MUL; end
      else start = 1'b0;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("stall_at_done", 32'(stall), 32'd0);
    if (poke_done && seen) begin
      start = 1'b1; alu_cntrl = ALU_DIV; op2 = 16'h0000;
      #1 chk("stall_done_poke", 32'(stall), 32'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, b;
    logic [3:0]  code;
    int          sel, lat;
    logic [15:0] edges [5];
    edges[0] = 16'h8000; edges[1] = 16'hFFFF; edges[2] = 16'h7FFF;
    edges[3] = 16'h0001; edges[4] = 16'h0000;

    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_cntrl = 4'h0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_hi", 32'(result_hi), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(ALU_MUL, 16'd7, 16'hFFFD, 1'b1);    wait_done(17, 16, 1'b0, 1'b0);
    issue(ALU_MUL, 16'h8000, 16'h8000, 1'b1); wait_done(17, 16, 1'b0, 1'b0);
    issue(ALU_DIV, 16'hFFEF, 16'd5, 1'b1);    wait_done(17, 16, 1'b0, 1'b0);
    issue(ALU_DIV, 16'h8000, 16'hFFFF, 1'b1); wait_done(17, 16, 1'b0, 1'b0);
    issue(ALU_DIV, 16'd100, 16'd0, 1'b1);     wait_done(1, 0, 1'b0, 1'b0);

    // Abort mid-calculation, then restart immediately
    issue(ALU_MUL, 16'h1234, 16'h0055, 1'b0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("stall_before_flush", 32'(stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("stall_after_flush", 32'(stall), 32'd0);
    chk("done_after_flush", 32'(done), 32'd0);
    issue(ALU_MUL, 16'd3, 16'd4, 1'b1);       wait_done(17, 16, 1'b0, 1'b0);

    // Flush in IDLE overrides a valid start
    flush = 1'b1; start = 1'b1; alu_cntrl = ALU_MUL; op1 = 16'd9; op2 = 16'd9;
    #1 chk("stall_flush_idle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #1 chk("idle_after_flush_start", 32'(stall), 32'd0);

    // Starts during CALC and DONE are ignored
    issue(ALU_MUL, 16'd25, 16'hFFF7, 1'b1);   wait_done(17, 16, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Unsupported ALU code
    start = 1'b1; alu_cntrl = 4'b0000; op1 = 16'd5; op2 = 16'd6;
    #1 chk("stall_bad_code", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    #1 chk("idle_after_bad_code", 32'(stall), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of an operation
    issue(ALU_MUL, 16'h0123, 16'h0456, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_div_zero", 32'(div_zero), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_result_hi", 32'(result_hi), 32'd0);
    repeat (20) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      code = ($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_DIV;
      a    = ($urandom_range(0, 5) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
      sel  = $urandom_range(0, 7);
      if (sel == 0)      b = 16'h0000;
      else if (sel == 1) b = edges[$urandom_range(0, 3)];
      else               b = 16'($urandom);
      lat = (code == ALU_DIV && b == 16'h0000) ? 1 : 17;
      issue(code, a, b, 1'b1);
      wait_done(lat, (lat == 1) ? 0 : 16, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
